dmem_result_responder: RTL and testbench

- Memory-mapped responder for the riscv_core data port (mem_d_* request/response protocol).
- Captures the values that self-checking test programs store into a bank of result words.
- Exposes an exit/status register whose write marks test completion.
- Sits beside tcm_mem on the data bus in core-level benches. Benches read results and the done flag directly, instead of decoding CSR opcodes and peeking into RAM.

---
 rtl/dmem_resp_pkg.sv | 19 +
 rtl/dmem_result_responder_if.sv | 41 ++++
 rtl/dmem_resp_pipe.sv | 30 +++
 rtl/dmem_result_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_result_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// dmem_resp_pkg - shared types and offsets for dmem_result_responder (rev 1.0)
// ============================================================================
package dmem_resp_pkg;

  localparam int          TAG_W      = 11;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0100;
  localparam logic [31:0] OFF_WRCNT  = 32'h0000_0104;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             error;
  } resp_stage_t;

endpackage
`default_nettype wire

// File: rtl/dmem_result_responder_if.sv
`default_nettype none
// ============================================================================
// dmem_result_responder_if - riscv_core data-port request/response bundle (rev 1.0)
// ============================================================================
interface dmem_result_responder_if
  import dmem_resp_pkg::*;
();

  logic [31:0]      mem_d_addr_i;
  logic [31:0]      mem_d_data_wr_i;
  logic             mem_d_rd_i;
  logic [3:0]       mem_d_wr_i;
  logic             mem_d_cacheable_i;
  logic [TAG_W-1:0] mem_d_req_tag_i;
  logic             mem_d_invalidate_i;
  logic             mem_d_writeback_i;
  logic             mem_d_flush_i;
  logic [31:0]      mem_d_data_rd_o;
  logic             mem_d_accept_o;
  logic             mem_d_ack_o;
  logic             mem_d_error_o;
  logic [TAG_W-1:0] mem_d_resp_tag_o;

  modport master (
    output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
           mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
           mem_d_writeback_i, mem_d_flush_i,
    input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
           mem_d_resp_tag_o
  );

  modport slave (
    input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
           mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
           mem_d_writeback_i, mem_d_flush_i,
    output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
           mem_d_resp_tag_o
  );

endinterface
`default_nettype wire

// File: rtl/dmem_resp_pipe.sv
`default_nettype none
// ============================================================================
// dmem_resp_pipe - fixed-latency response shift register, async active-low clear (rev 1.0)
// ============================================================================
module dmem_resp_pipe
  import dmem_resp_pkg::*;
#(
  parameter int RESP_LATENCY = 1
) (
  input  wire logic  clk,
  input  wire logic  rst,
  input  resp_stage_t i_stage,
  output resp_stage_t o_stage
);

  resp_stage_t r_pipe [RESP_LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RESP_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_stage;
      for (int i = 1; i < RESP_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_stage = r_pipe[RESP_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/dmem_result_responder.sv
`default_nettype none
// ============================================================================
// dmem_result_responder - result-word bank + STATUS/exit register on the data bus (rev 1.0)
// Optional back-pressure injection: define DMEM_RESP_STALL_INJECT_EN.
// ============================================================================
module dmem_result_responder
  import dmem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h9000_0000,
  parameter int          NUM_RESULTS  = 16,
  parameter int          RESP_LATENCY = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  dmem_result_responder_if.slave  bus,
  output logic                    done_o,
  output logic [31:0]             exit_code_o,
  output logic [15:0]             wr_count_o,
  input  wire logic [5:0]         dbg_idx_i,
  output logic [31:0]             dbg_data_o
);

  logic [31:0] r_res [NUM_RESULTS];
  logic        r_done;
  logic [31:0] r_exit;
  logic [15:0] r_wr_cnt;

  logic        w_accept;
  logic        w_maint;
  logic        w_is_wr;
  logic        w_access;
  logic        w_req;
  logic        w_take;
  logic [31:0] w_off;
  logic [5:0]  w_idx;
  logic        w_in_res;
  logic        w_is_status;
  logic        w_is_wrcnt;
  logic        w_err;
  logic        w_wr_res;
  logic        w_wr_stat;
  logic [31:0] w_res_rd;
  logic [31:0] w_rd_data;
  resp_stage_t w_stage_in;
  resp_stage_t w_stage_out;
  logic        w_unused;

`ifdef DMEM_RESP_STALL_INJECT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lfsr <= 16'hACE1;
    else      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
  end

  assign w_accept = rst & ~r_lfsr[0];
`else
  assign w_accept = rst;
`endif

  assign w_maint     = bus.mem_d_invalidate_i | bus.mem_d_writeback_i | bus.mem_d_flush_i;
  assign w_is_wr     = |bus.mem_d_wr_i;
  assign w_access    = bus.mem_d_rd_i | w_is_wr;
  assign w_req       = w_access | w_maint;
  assign w_take      = w_req & w_accept;
  // Addresses below the window wrap to huge offsets and fall out of every region
  assign w_off       = bus.mem_d_addr_i - BASE_ADDR;
  assign w_idx       = w_off[7:2];
  assign w_in_res    = w_off < 32'(4 * NUM_RESULTS);
  assign w_is_status = w_off == OFF_STATUS;
  assign w_is_wrcnt  = w_off == OFF_WRCNT;
  assign w_unused    = bus.mem_d_cacheable_i;

  // Maintenance-only requests never error; address checks apply to rd/wr only
  assign w_err = w_access & ((bus.mem_d_addr_i[1:0] != 2'b00)
                           | ~(w_in_res | w_is_status | w_is_wrcnt)
                           | (w_is_wr & w_is_wrcnt)
                           | (bus.mem_d_rd_i & w_is_wr)
                           | w_maint);

  assign w_wr_res  = w_take & w_is_wr & ~w_err & w_in_res;
  assign w_wr_stat = w_take & w_is_wr & ~w_err & w_is_status;

  always_comb begin
    w_res_rd   = '0;
    dbg_data_o = '0;
    for (int i = 0; i < NUM_RESULTS; i++) begin
      if (w_idx == 6'(i))     w_res_rd   = r_res[i];
      if (dbg_idx_i == 6'(i)) dbg_data_o = r_res[i];
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (bus.mem_d_rd_i && !w_err) begin
      if (w_in_res)         w_rd_data = w_res_rd;
      else if (w_is_status) w_rd_data = r_exit;
      else                  w_rd_data = {16'b0, r_wr_cnt};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RESULTS; i++) r_res[i] <= '0;
      r_done   <= 1'b0;
      r_exit   <= '0;
      r_wr_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
        if (w_wr_res && w_idx == 6'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.mem_d_wr_i[b]) r_res[i][8*b +: 8] <= bus.mem_d_data_wr_i[8*b +: 8];
          end
        end
      end
      if (w_wr_res && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_wr_stat) begin
        r_exit <= bus.mem_d_data_wr_i;
        r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    w_stage_in       = '0;
    w_stage_in.valid = w_take;
    w_stage_in.tag   = bus.mem_d_req_tag_i;
    w_stage_in.data  = w_rd_data;
    w_stage_in.error = w_err;
  end

  dmem_resp_pipe #(
    .RESP_LATENCY (RESP_LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_stage (w_stage_in),
    .o_stage (w_stage_out)
  );

  assign bus.mem_d_accept_o   = w_accept;
  assign bus.mem_d_ack_o      = w_stage_out.valid;
  assign bus.mem_d_error_o    = w_stage_out.error;
  assign bus.mem_d_data_rd_o  = w_stage_out.data;
  assign bus.mem_d_resp_tag_o = w_stage_out.tag;
  assign done_o               = r_done;
  assign exit_code_o          = r_exit;
  assign wr_count_o           = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_result_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_result_responder - scoreboarded directed bench for dmem_result_responder (rev 1.0)
// ============================================================================
module tb_dmem_result_responder;

  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int          NR   = 16;
  localparam int          LAT  = 3;

  typedef struct {
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  dbg_idx = '0;
  logic        done;
  logic [31:0] exit_code;
  logic [15:0] wr_count;
  logic [31:0] dbg_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t q[$];

  logic [31:0] m_res [NR];
  logic [31:0] m_exit;
  logic [15:0] m_cnt;
  logic [15:0] m_lfsr;

  dmem_result_responder_if bus();

  dmem_result_responder #(
    .BASE_ADDR    (BASE),
    .NUM_RESULTS  (NR),
    .RESP_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .done_o      (done),
    .exit_code_o (exit_code),
    .wr_count_o  (wr_count),
    .dbg_idx_i   (dbg_idx),
    .dbg_data_o  (dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_res[i] = '0;
    m_exit = '0;
    m_cnt  = '0;
  endtask

  // Reference model applied at the acceptance point; pushes the expected response
  task automatic model_req(input logic rd, input logic [3:0] wr, input logic [2:0] mnt,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [10:0] tag);
    logic [31:0] off;
    logic        acc;
    logic        err;
    logic [31:0] data;
    exp_t        e;
    off  = addr - BASE;
    acc  = rd || (wr != 4'b0);
    err  = 1'b0;
    data = '0;
    if (acc) begin
      if (addr[1:0] != 2'b00) err = 1'b1;
      if (!(off < 4*NR || off == 32'h100 || off == 32'h104)) err = 1'b1;
      if (wr != 4'b0 && off == 32'h104) err = 1'b1;
      if (rd && wr != 4'b0) err = 1'b1;
      if (mnt != 3'b0) err = 1'b1;
    end
    if (!err && rd) begin
      if (off < 4*NR)          data = m_res[off[5:2]];
      else if (off == 32'h100) data = m_exit;
      else                     data = {16'b0, m_cnt};
    end
    if (!err && wr != 4'b0) begin
      if (off < 4*NR) begin
        for (int b = 0; b < 4; b++) if (wr[b]) m_res[off[5:2]][8*b +: 8] = wd[8*b +: 8];
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (off == 32'h100) begin
        m_exit = wd;
      end
    end
    e.tag  = tag;
    e.data = data;
    e.err  = err;
    e.cyc  = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic bus_idle();
    bus.mem_d_addr_i       = '0;
    bus.mem_d_data_wr_i    = '0;
    bus.mem_d_rd_i         = 1'b0;
    bus.mem_d_wr_i         = '0;
    bus.mem_d_cacheable_i  = 1'b0;
    bus.mem_d_req_tag_i    = '0;
    bus.mem_d_invalidate_i = 1'b0;
    bus.mem_d_writeback_i  = 1'b0;
    bus.mem_d_flush_i      = 1'b0;
  endtask

  // Holds the request until accept_o is seen, then returns just after the taking edge
  task automatic issue(input logic rd, input logic [3:0] wr, input logic [2:0] mnt,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [10:0] tag);
    bit taken = 0;
    int tries = 0;
    bus.mem_d_addr_i       = addr;
    bus.mem_d_data_wr_i    = wd;
    bus.mem_d_rd_i         = rd;
    bus.mem_d_wr_i         = wr;
    bus.mem_d_cacheable_i  = 1'b1;
    bus.mem_d_req_tag_i    = tag;
    bus.mem_d_invalidate_i = mnt[0];
    bus.mem_d_writeback_i  = mnt[1];
    bus.mem_d_flush_i      = mnt[2];
    while (!taken) begin
      @(negedge clk);
      if (bus.mem_d_accept_o) begin
        model_req(rd, wr, mnt, addr, wd, tag);
        taken = 1;
      end else if (++tries > 64) begin
        chk("accept_timeout", {31'b0, bus.mem_d_accept_o}, 32'd1);
        taken = 1;
      end
      @(posedge clk);
      #1;
    end
    bus_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.mem_d_ack_o === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", {31'b0, bus.mem_d_ack_o}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_tag",   {21'b0, bus.mem_d_resp_tag_o}, {21'b0, e.tag});
        chk("ack_data",  bus.mem_d_data_rd_o, e.data);
        chk("ack_error", {31'b0, bus.mem_d_error_o}, {31'b0, e.err});
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int wait_cnt;
    bus_idle();
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_accept", {31'b0, bus.mem_d_accept_o}, 32'd0);
    chk("rst_ack",    {31'b0, bus.mem_d_ack_o}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    chk("rst_exit",   exit_code, 32'd0);
    chk("rst_wrcnt",  {16'b0, wr_count}, 32'd0);
    chk("rst_dbg",    dbg_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // accept_o pattern right after reset
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
`ifdef DMEM_RESP_STALL_INJECT_EN
      chk("lfsr_accept", {31'b0, bus.mem_d_accept_o}, {31'b0, ~m_lfsr[0]});
`else
      chk("accept_high", {31'b0, bus.mem_d_accept_o}, 32'd1);
`endif
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
    end
    @(posedge clk);
    #1;

    // Write then read back a result word
    issue(1'b0, 4'hF, 3'b0, BASE + 32'h8, 32'hDEADBEEF, 11'h05);
    issue(1'b1, 4'h0, 3'b0, BASE + 32'h8, 32'h0, 11'h06);
    idle(LAT + 1);
    chk("wrcnt_after_first", {16'b0, wr_count}, 32'd1);
    dbg_idx = 6'd2;
    #1 chk("dbg_idx2", dbg_data, 32'hDEADBEEF);

    // Byte-enable merge
    issue(1'b0, 4'hF,    3'b0, BASE + 32'hC, 32'h11223344, 11'h07);
    issue(1'b0, 4'b0100, 3'b0, BASE + 32'hC, 32'h00AB0000, 11'h08);
    issue(1'b1, 4'h0,    3'b0, BASE + 32'hC, 32'h0, 11'h09);
    dbg_idx = 6'd3;
    #1 chk("byte_merge", dbg_data, 32'h11AB3344);
    dbg_idx = 6'd16;
    #1 chk("dbg_out_of_range", dbg_data, 32'd0);

    // STATUS write sets done the cycle after acceptance
    chk("done_before", {31'b0, done}, 32'd0);
    issue(1'b0, 4'h3, 3'b0, BASE + 32'h100, 32'h1, 11'h0A);
    chk("done_after", {31'b0, done}, 32'd1);
    chk("exit_code", exit_code, 32'h1);
    issue(1'b1, 4'h0, 3'b0, BASE + 32'h104, 32'h0, 11'h0B);
    issue(1'b1, 4'h0, 3'b0, BASE + 32'h100, 32'h0, 11'h0C);

    // Error and maintenance cases
    issue(1'b1, 4'h0, 3'b0,   BASE + 32'h2,   32'h0,        11'h20);
    issue(1'b1, 4'h0, 3'b0,   BASE + 32'h200, 32'h0,        11'h21);
    issue(1'b0, 4'hF, 3'b0,   BASE + 32'h104, 32'h12345678, 11'h22);
    issue(1'b1, 4'hF, 3'b0,   BASE + 32'h0,   32'h55555555, 11'h23);
    issue(1'b0, 4'hF, 3'b001, BASE + 32'h4,   32'h66666666, 11'h24);
    issue(1'b1, 4'h0, 3'b0,   BASE - 32'h4,   32'h0,        11'h25);
    issue(1'b0, 4'h0, 3'b110, BASE + 32'h3,   32'h0,        11'h26);
    idle(LAT + 1);
    chk("wrcnt_after_errors", {16'b0, wr_count}, 32'd3);

    // Back-to-back traffic, still serviced after done
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        issue(1'b0, 4'hF, 3'b0, BASE + 32'(4 * (8 + i / 2)), 32'(i * 32'h1111), 11'(8'h10 + i));
      else
        issue(1'b1, 4'h0, 3'b0, BASE + 32'(4 * (8 + i / 2)), 32'h0, 11'(8'h10 + i));
    end
    idle(LAT + 1);
    chk("done_sticky", {31'b0, done}, 32'd1);
    chk("wrcnt_after_burst", {16'b0, m_cnt}, {16'b0, wr_count});
    chk("wrcnt_value", {16'b0, wr_count}, 32'd7);

    // Reset with two responses in flight
    issue(1'b0, 4'hF, 3'b0, BASE + 32'h14, 32'hCAFEF00D, 11'h30);
    issue(1'b0, 4'hF, 3'b0, BASE + 32'h18, 32'hBAADF00D, 11'h31);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("inflight_dropped", {31'b0, bus.mem_d_ack_o}, 32'd0);
    end
    dbg_idx = 6'd5;
    #1 chk("mid_rst_result", dbg_data, 32'd0);
    chk("mid_rst_done",  {31'b0, done}, 32'd0);
    chk("mid_rst_wrcnt", {16'b0, wr_count}, 32'd0);
    chk("mid_rst_exit",  exit_code, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();

    // Recovery after reset
    issue(1'b1, 4'h0, 3'b0, BASE + 32'h8, 32'h0, 11'h40);
    issue(1'b0, 4'hF, 3'b0, BASE + 32'h3C, 32'hA5A5A5A5, 11'h41);
    issue(1'b1, 4'h0, 3'b0, BASE + 32'h3C, 32'h0, 11'h42);

    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    chk("drain_pending", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
